// File: rtl/fetch_sequencer.sv
// Front-end PC sequencer: owns the fetch PC, issues one instruction-memory request at a time,
// squashes stale responses after a redirect and buffers one extra instruction while decode stalls.
module fetch_sequencer #(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  stall_i,
    input  logic                  redirect_i,
    input  logic [DATA_WIDTH-1:0] redirect_pc_i,
    output logic                  imem_req_o,
    output logic [DATA_WIDTH-1:0] imem_addr_o,
    input  logic                  imem_gnt_i,
    input  logic                  imem_rvalid_i,
    input  logic [31:0]           imem_rdata_i,
    output logic                  instr_valid_o,
    output logic [31:0]           instr_o,
    output logic [DATA_WIDTH-1:0] instr_pc_o,
    output logic                  flush_o
);

    localparam logic [1:0] ST_BOOT = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam logic [1:0] ST_DROP = 2'd3;

    logic [1:0]            state_q, state_d;
    logic [DATA_WIDTH-1:0] pc_q, pc_d;
    logic [DATA_WIDTH-1:0] req_pc_q, req_pc_d;
    logic                  out_valid_q, out_valid_d;
    logic [31:0]           out_instr_q, out_instr_d;
    logic [DATA_WIDTH-1:0] out_pc_q, out_pc_d;
    logic                  skid_valid_q, skid_valid_d;
    logic [31:0]           skid_instr_q, skid_instr_d;
    logic [DATA_WIDTH-1:0] skid_pc_q, skid_pc_d;
    logic                  flush_q, flush_d;
    logic                  out_free;
    logic                  consume;
    logic                  req_fire;
    logic                  unused_redirect_lsbs;

    // Word alignment discards the low target bits.
    assign unused_redirect_lsbs = ^redirect_pc_i[1:0];

    // Request side depends on registered state only.
    assign imem_req_o    = (state_q == ST_REQ) && !skid_valid_q;
    assign imem_addr_o   = pc_q;
    assign instr_valid_o = out_valid_q;
    assign instr_o       = out_instr_q;
    assign instr_pc_o    = out_pc_q;
    assign flush_o       = flush_q;

    assign out_free = !out_valid_q || !stall_i;
    assign consume  = out_valid_q && !stall_i;
    assign req_fire = imem_req_o && imem_gnt_i;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        req_pc_d     = req_pc_q;
        out_valid_d  = out_valid_q;
        out_instr_d  = out_instr_q;
        out_pc_d     = out_pc_q;
        skid_valid_d = skid_valid_q;
        skid_instr_d = skid_instr_q;
        skid_pc_d    = skid_pc_q;
        flush_d      = 1'b0;

        if (consume) begin
            if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                out_instr_d  = skid_instr_q;
                out_pc_d     = skid_pc_q;
                skid_valid_d = 1'b0;
            end else begin
                out_valid_d = 1'b0;
            end
        end

        case (state_q)
            ST_BOOT: state_d = ST_REQ;
            ST_REQ: begin
                if (req_fire) begin
                    req_pc_d = pc_q;
                    pc_d     = pc_q + DATA_WIDTH'(4);
                    state_d  = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (imem_rvalid_i) begin
                    state_d = ST_REQ;
                    if (out_free && !skid_valid_q) begin
                        out_valid_d = 1'b1;
                        out_instr_d = imem_rdata_i;
                        out_pc_d    = req_pc_q;
                    end else begin
                        // Either the output is blocked or the skid entry just advanced into it.
                        skid_valid_d = 1'b1;
                        skid_instr_d = imem_rdata_i;
                        skid_pc_d    = req_pc_q;
                    end
                end
            end
            ST_DROP: begin
                if (imem_rvalid_i) begin
                    state_d = ST_REQ;
                end
            end
            default: state_d = ST_BOOT;
        endcase

        if (redirect_i) begin
            pc_d         = {redirect_pc_i[DATA_WIDTH-1:2], 2'b00};
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
            flush_d      = 1'b1;
            case (state_q)
                ST_BOOT: state_d = ST_REQ;
                ST_REQ:  state_d = req_fire ? ST_DROP : ST_REQ;
                ST_WAIT: state_d = imem_rvalid_i ? ST_REQ : ST_DROP;
                default: state_d = ST_DROP;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q      <= ST_BOOT;
            pc_q         <= RESET_PC;
            req_pc_q     <= '0;
            out_valid_q  <= 1'b0;
            out_instr_q  <= '0;
            out_pc_q     <= '0;
            skid_valid_q <= 1'b0;
            skid_instr_q <= '0;
            skid_pc_q    <= '0;
            flush_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            req_pc_q     <= req_pc_d;
            out_valid_q  <= out_valid_d;
            out_instr_q  <= out_instr_d;
            out_pc_q     <= out_pc_d;
            skid_valid_q <= skid_valid_d;
            skid_instr_q <= skid_instr_d;
            skid_pc_q    <= skid_pc_d;
            flush_q      <= flush_d;
        end
    end

endmodule
